// File: rtl/snes_pkg.sv
// Shared constants and FSM state type for the SNES pad reader.
package snes_pkg;
  localparam int BTN_B       = 0;
  localparam int BTN_Y       = 1;
  localparam int BTN_SEL     = 2;
  localparam int BTN_START   = 3;
  localparam int BTN_UP      = 4;
  localparam int BTN_DOWN    = 5;
  localparam int BTN_LEFT    = 6;
  localparam int BTN_RIGHT   = 7;
  localparam int BTN_A       = 8;
  localparam int BTN_X       = 9;
  localparam int BTN_L       = 10;
  localparam int BTN_R       = 11;
  localparam int NUM_BUTTONS = 12;
  localparam int FRAME_BITS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LATCH, ST_SETTLE, ST_CLK_LOW, ST_CLK_HIGH, ST_DONE
  } state_t;
endpackage

// File: rtl/snes_controller_reader_if.sv
// Three-wire pad bus: reader drives latch/clock, pad drives serial data.
interface snes_controller_reader_if;
  logic ctrl_data;
  logic ctrl_latch;
  logic ctrl_clock;

  modport master (input ctrl_data, output ctrl_latch, output ctrl_clock);
  modport slave  (output ctrl_data, input ctrl_latch, input ctrl_clock);
endinterface

// File: rtl/counter.sv
// Generic up/down counter with synchronous load (load wins over count).
module counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         en,
  input  logic         load,
  input  logic         up,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)      q <= '0;
    else if (load)   q <= d;
    else if (en)     q <= up ? q + W'(1) : q - W'(1);
  end
endmodule

// File: rtl/snes_controller_reader.sv
// Periodic SNES pad poller: latch, 16 clock pulses, frame check, atomic button update.
module snes_controller_reader
  import snes_pkg::*;
#(
  parameter int HALF_PERIOD  = 300,
  parameter int LATCH_CYCLES = 600,
  parameter int POLL_CYCLES  = 833_333
) (
  input  logic                   clk,
  input  logic                   rst_l,
  snes_controller_reader_if.master pad,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic                   buttons_valid,
  output logic                   ctrl_error
);
  localparam int POLL_W = $clog2(POLL_CYCLES);
  localparam int PH_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int BIT_W  = $clog2(FRAME_BITS);

  if (POLL_CYCLES <= LATCH_CYCLES + 33*HALF_PERIOD + 2) begin : g_bad_params
    $error("POLL_CYCLES too short to hold one full frame");
  end

  state_t                state, state_next;
  logic [1:0]            sync;
  logic                  data_s;
  logic [POLL_W-1:0]     poll_q;
  logic [PH_W-1:0]       phase_q, phase_end;
  logic [BIT_W-1:0]      bit_q, sample_idx;
  logic                  poll_wrap, phase_last, sample_en, bit_inc;
  logic [FRAME_BITS-1:0] shreg;
  logic                  latch_q, clock_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) sync <= 2'b11;
    else        sync <= {sync[0], pad.ctrl_data};
  end
  assign data_s = sync[1];

  assign poll_wrap  = (poll_q == POLL_W'(POLL_CYCLES - 1));
  assign phase_end  = (state == ST_LATCH) ? PH_W'(LATCH_CYCLES - 1) : PH_W'(HALF_PERIOD - 1);
  assign phase_last = (phase_q == phase_end);

  counter #(.W(POLL_W)) u_poll (
    .clk(clk), .rst_l(rst_l), .en(1'b1), .load(poll_wrap), .up(1'b1), .d('0), .q(poll_q)
  );
  counter #(.W(PH_W)) u_phase (
    .clk(clk), .rst_l(rst_l), .en(state != ST_IDLE), .load(state_next != state),
    .up(1'b1), .d('0), .q(phase_q)
  );
  counter #(.W(BIT_W)) u_bit (
    .clk(clk), .rst_l(rst_l), .en(bit_inc), .load(state == ST_IDLE),
    .up(1'b1), .d('0), .q(bit_q)
  );

  always_comb begin
    state_next = state;
    sample_en  = 1'b0;
    sample_idx = bit_q + BIT_W'(1);
    bit_inc    = 1'b0;
    unique case (state)
      ST_IDLE:     if (poll_wrap) state_next = ST_LATCH;
      ST_LATCH:    if (phase_last) state_next = ST_SETTLE;
      ST_SETTLE:   if (phase_last) begin
        sample_en  = 1'b1;
        sample_idx = '0;
        state_next = ST_CLK_LOW;
      end
      ST_CLK_LOW:  if (phase_last) state_next = ST_CLK_HIGH;
      ST_CLK_HIGH: if (phase_last) begin
        if (bit_q != BIT_W'(FRAME_BITS - 1)) begin
          sample_en  = 1'b1;
          bit_inc    = 1'b1;
          state_next = ST_CLK_LOW;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Pad outputs are registered from next-state so they never glitch on decode.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= ST_IDLE;
      shreg         <= '0;
      latch_q       <= 1'b0;
      clock_q       <= 1'b1;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      ctrl_error    <= 1'b0;
    end else begin
      state         <= state_next;
      latch_q       <= (state_next == ST_LATCH);
      clock_q       <= (state_next != ST_CLK_LOW);
      buttons_valid <= 1'b0;
      if (sample_en) shreg[sample_idx] <= ~data_s;
      if (state == ST_DONE) begin
        // Real pads shift out 1s (unpressed) for the four unused bits.
        if (shreg[FRAME_BITS-1:NUM_BUTTONS] == '0) begin
          buttons       <= shreg[NUM_BUTTONS-1:0];
          buttons_valid <= 1'b1;
          ctrl_error    <= 1'b0;
        end else begin
          ctrl_error    <= 1'b1;
        end
      end
    end
  end

  assign pad.ctrl_latch = latch_q;
  assign pad.ctrl_clock = clock_q;
endmodule

// File: tb/tb_snes_controller_reader.sv
// Directed bench: pad model, per-poll vector table, reset/timing corner sequences.
module tb_snes_controller_reader;
  import snes_pkg::*;

  localparam int HP    = 30;
  localparam int LC    = 60;
  localparam int PC    = 1500;
  localparam int FRAME = LC + 33*HP + 1;
  localparam int SHP   = 2;
  localparam int SLC   = 3;
  localparam int SPC   = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l = 1'b0, rst_s_l = 1'b0;
  logic [11:0] buttons, s_buttons;
  logic        valid, err, s_valid, s_err;

  snes_controller_reader_if pif();
  snes_controller_reader_if sif();

  snes_controller_reader #(.HALF_PERIOD(HP), .LATCH_CYCLES(LC), .POLL_CYCLES(PC)) dut (
    .clk(clk), .rst_l(rst_l), .pad(pif),
    .buttons(buttons), .buttons_valid(valid), .ctrl_error(err)
  );
  snes_controller_reader #(.HALF_PERIOD(SHP), .LATCH_CYCLES(SLC), .POLL_CYCLES(SPC)) dut_s (
    .clk(clk), .rst_l(rst_s_l), .pad(sif),
    .buttons(s_buttons), .buttons_valid(s_valid), .ctrl_error(s_err)
  );

  // Pad model: mode 0 = normal pad, 1 = line stuck low, 2 = disconnected (pull-up).
  int          pad_mode = 2;
  logic [11:0] pad_word = '0;
  logic [15:0] pad_frame;
  int          pad_idx = 0;
  assign pad_frame = {4'h0, pad_word};
  always @(posedge pif.ctrl_clock or posedge pif.ctrl_latch) begin
    if (pif.ctrl_latch) pad_idx <= 0;
    else                pad_idx <= pad_idx + 1;
  end
  assign pif.ctrl_data = (pad_mode == 1) ? 1'b0 :
                         (pad_mode == 2) ? 1'b1 :
                         (pad_idx < 16)  ? ~pad_frame[pad_idx[3:0]] : 1'b0;
  assign sif.ctrl_data = 1'b1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] prev_btn = '0;
  int          bad_changes = 0;
  int          vtotal = 0;
  always @(negedge clk) begin
    if (rst_l && buttons !== prev_btn && !valid) bad_changes++;
    if (valid) vtotal++;
    prev_btn = buttons;
  end

  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_latch_rise(output int t);
    int   n = 0;
    logic was = pif.ctrl_latch;
    t = -1;
    while (n < PC + 20) begin
      @(negedge clk);
      n++;
      if (pif.ctrl_latch && !was) begin t = cyc; break; end
      was = pif.ctrl_latch;
    end
    if (t < 0) begin
      check("latch_timeout", 0, 1);
      t = cyc;
    end
  endtask

  // Walks one frame from the first latch-high negedge, measuring waveform and valid timing.
  task automatic run_frame(input int t0, output int lat_hi, output int nlow,
                           output int badw, output int vcnt, output int vlat);
    int run = 0;
    lat_hi = 0; nlow = 0; badw = 0; vcnt = 0; vlat = -1;
    for (int i = 0; i < FRAME + 8; i++) begin
      if (pif.ctrl_latch) lat_hi++;
      if (!pif.ctrl_clock) run++;
      else if (run > 0) begin
        nlow++;
        if (run != HP) badw++;
        run = 0;
      end
      if (valid) begin vcnt++; vlat = cyc - t0; end
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          mode;
    logic [11:0] word;
    logic [11:0] exp_btn;
    int          exp_valid;
    logic        exp_err;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int t_rel, t0, lat_hi, nlow, badw, vcnt, vlat, vmark, mism, o;
    logic e_latch, e_clk, e_valid;

    tbl[0]  = '{0, 12'((1<<BTN_B)|(1<<BTN_RIGHT)), 12'h081, 1, 1'b0};
    tbl[1]  = '{0, 12'((1<<BTN_B)|(1<<BTN_RIGHT)), 12'h081, 1, 1'b0};
    tbl[2]  = '{0, 12'((1<<BTN_B)|(1<<BTN_RIGHT)), 12'h081, 1, 1'b0};
    tbl[3]  = '{0, 12'(1<<BTN_START),              12'h008, 1, 1'b0};
    tbl[4]  = '{0, 12'((1<<BTN_L)|(1<<BTN_R)),     12'hC00, 1, 1'b0};
    tbl[5]  = '{0, 12'h081,                        12'h081, 1, 1'b0};
    tbl[6]  = '{1, 12'h000,                        12'h081, 0, 1'b1};
    tbl[7]  = '{1, 12'h000,                        12'h081, 0, 1'b1};
    tbl[8]  = '{0, 12'h5A5,                        12'h5A5, 1, 1'b0};
    tbl[9]  = '{2, 12'h000,                        12'h000, 1, 1'b0};
    tbl[10] = '{0, 12'hFFF,                        12'hFFF, 1, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    check("rst_latch", pif.ctrl_latch, 0);
    check("rst_clock", pif.ctrl_clock, 1);
    check("rst_buttons", buttons, 0);
    check("rst_valid", valid, 0);
    check("rst_error", err, 0);

    // First frame with pad disconnected: timing and waveform shape.
    @(negedge clk); rst_l = 1'b1; t_rel = cyc;
    wait_latch_rise(t0);
    check("first_poll_delay", t0 - t_rel, PC);
    check("buttons_before_valid", buttons, 0);
    run_frame(t0, lat_hi, nlow, badw, vcnt, vlat);
    check("latch_width", lat_hi, LC);
    check("clock_pulses", nlow, 16);
    check("clock_low_width_bad", badw, 0);
    check("f0_valid_count", vcnt, 1);
    check("f0_valid_latency", vlat, FRAME);
    check("f0_buttons", buttons, 0);
    check("f0_error", err, 0);

    for (int i = 0; i < 11; i++) begin
      pad_mode = tbl[i].mode;
      pad_word = tbl[i].word;
      wait_latch_rise(t0);
      run_frame(t0, lat_hi, nlow, badw, vcnt, vlat);
      check($sformatf("v%0d_valid_count", i), vcnt, tbl[i].exp_valid);
      if (tbl[i].exp_valid != 0) check($sformatf("v%0d_latency", i), vlat, FRAME);
      check($sformatf("v%0d_buttons", i), buttons, tbl[i].exp_btn);
      check($sformatf("v%0d_error", i), err, tbl[i].exp_err);
    end

    // Reset during the low phase of pulse 7 of a 12'hFFF frame.
    wait_latch_rise(t0);
    repeat (LC + HP + 14*HP + HP/2) @(negedge clk);
    check("pre_reset_clock_low", pif.ctrl_clock, 0);
    #2 rst_l = 1'b0;
    #1;
    check("mid_rst_latch", pif.ctrl_latch, 0);
    check("mid_rst_clock", pif.ctrl_clock, 1);
    check("mid_rst_buttons", buttons, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_error", err, 0);
    repeat (2) @(negedge clk);
    pad_mode = 0; pad_word = 12'h123;
    rst_l = 1'b1; t_rel = cyc; vmark = vtotal;
    wait_latch_rise(t0);
    check("post_rst_poll_delay", t0 - t_rel, PC);
    check("post_rst_no_early_valid", vtotal - vmark, 0);
    check("post_rst_buttons_clear", buttons, 0);
    run_frame(t0, lat_hi, nlow, badw, vcnt, vlat);
    check("post_rst_valid_count", vcnt, 1);
    check("post_rst_latency", vlat, FRAME);
    check("post_rst_buttons", buttons, 12'h123);
    check("buttons_change_without_valid", bad_changes, 0);

    // Small-parameter instance against an arithmetic waveform model.
    @(negedge clk); rst_s_l = 1'b1; t_rel = cyc; mism = 0;
    for (int i = 0; i < 3*SPC; i++) begin
      o = cyc - t_rel;
      e_latch = 1'b0; e_clk = 1'b1; e_valid = 1'b0;
      if (o >= SPC) begin
        o = o % SPC;
        e_latch = (o < SLC);
        if (o >= SLC + SHP && o < SLC + 33*SHP) e_clk = (((o - SLC - SHP) / SHP) % 2) != 0;
        e_valid = (o == SLC + 33*SHP + 1);
      end
      if (sif.ctrl_latch !== e_latch || sif.ctrl_clock !== e_clk || s_valid !== e_valid) mism++;
      @(negedge clk);
    end
    check("small_wave_mismatches", mism, 0);
    check("small_buttons", s_buttons, 0);
    check("small_error", s_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
